// File: rtl/mem_access.sv
// mem_access: memory-access pipeline stage that runs load/store bus cycles and aligns load data.
// Define MEM_BUS_TIMEOUT_EN to abort a bus cycle after BUS_TIMEOUT WAIT cycles without i_bus_rdy.
module mem_access #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int REGNO_WIDTH = 5,
    parameter int BUS_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_exec_stall,
    input  logic                   i_fetch_stall,
    input  logic                   i_nullify,
    input  logic [REGNO_WIDTH-1:0] i_rd_no,
    input  logic [DATA_WIDTH-1:0]  i_alu_result,
    input  logic [1:0]             i_lsu_op,
    input  logic                   i_lsu_lns,
    input  logic                   i_lsu_ext,
    input  logic [DATA_WIDTH-1:0]  i_mem_data,
    output logic [ADDR_WIDTH-1:0]  o_bus_addr,
    output logic                   o_bus_cmd,
    output logic                   o_bus_rnw,
    output logic [DATA_WIDTH-1:0]  o_bus_wdata,
    output logic [3:0]             o_bus_ben,
    input  logic                   i_bus_rdy,
    input  logic [DATA_WIDTH-1:0]  i_bus_data,
    input  logic                   i_bus_err,
    output logic                   o_mem_stall,
    output logic                   o_addr_error,
    output logic                   o_bus_error,
    output logic [REGNO_WIDTH-1:0] o_rd_no,
    output logic [DATA_WIDTH-1:0]  o_rd_val
);

    localparam logic [1:0] OP_IDLE = 2'd0;
    localparam logic [1:0] OP_BYTE = 2'd1;
    localparam logic [1:0] OP_HALF = 2'd2;
    localparam logic [1:0] OP_WORD = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t state_q, state_d;

    logic ext_stall, core_stall, misaligned, accept, start, timeout;

    logic [ADDR_WIDTH-1:0]  addr_q;
    logic                   rnw_q;
    logic [3:0]             ben_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic                   err_q;
    logic                   berr_q;
    logic [REGNO_WIDTH-1:0] rd_no_q;
    logic [DATA_WIDTH-1:0]  rd_val_q;

    logic [REGNO_WIDTH-1:0] rd_q;
    logic [1:0]             size_q;
    logic [1:0]             lo_q;
    logic                   ext_q;
    logic [DATA_WIDTH-1:0]  rdata_q;

    function automatic logic [3:0] lane_ben(input logic [1:0] size, input logic [1:0] a);
        case (size)
            OP_BYTE: lane_ben = 4'b0001 << a;
            OP_HALF: lane_ben = a[1] ? 4'b1100 : 4'b0011;
            OP_WORD: lane_ben = 4'b1111;
            default: lane_ben = 4'b0000;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] lane_wdata(input logic [1:0] size,
                                                         input logic [DATA_WIDTH-1:0] d);
        case (size)
            OP_BYTE: lane_wdata = {4{d[7:0]}};
            OP_HALF: lane_wdata = {2{d[15:0]}};
            default: lane_wdata = d;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] load_align(input logic [1:0] size,
                                                         input logic [1:0] a,
                                                         input logic ext,
                                                         input logic [DATA_WIDTH-1:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{a, 3'b000} +: 8];
        h = a[1] ? d[31:16] : d[15:0];
        case (size)
            OP_BYTE: load_align = {{(DATA_WIDTH-8){ext & b[7]}}, b};
            OP_HALF: load_align = {{(DATA_WIDTH-16){ext & h[15]}}, h};
            default: load_align = d;
        endcase
    endfunction

    assign ext_stall  = i_exec_stall | i_fetch_stall;
    assign core_stall = ext_stall | o_mem_stall;
    assign misaligned = ((i_lsu_op == OP_HALF) && i_alu_result[0]) ||
                        ((i_lsu_op == OP_WORD) && (i_alu_result[1:0] != 2'b00));
    // An instruction is only acted on while the upstream stages are moving, so a held one is not replayed.
    assign accept = (state_q == S_IDLE) && !ext_stall && !i_nullify && (i_lsu_op != OP_IDLE);
    assign start  = accept && !misaligned;

`ifdef MEM_BUS_TIMEOUT_EN
    logic [7:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (start) begin
            cnt_q <= '0;
        end else if ((state_q == S_WAIT) && !i_bus_rdy) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign timeout = (state_q == S_WAIT) && !i_bus_rdy && (cnt_q == 8'(BUS_TIMEOUT - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_WAIT;
            S_WAIT:  if (i_bus_rdy || timeout) state_d = S_DONE;
            S_DONE:  if (!ext_stall) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_bus_cmd    = 1'b0;
        o_mem_stall  = 1'b0;
        o_addr_error = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                o_mem_stall  = start;
                o_addr_error = accept && misaligned;
            end
            S_WAIT: begin
                o_bus_cmd   = 1'b1;
                o_mem_stall = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            rnw_q    <= 1'b0;
            ben_q    <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            berr_q   <= 1'b0;
            rd_no_q  <= '0;
            rd_val_q <= '0;
        end else begin
            berr_q <= 1'b0;
            if (start) begin
                addr_q  <= {i_alu_result[ADDR_WIDTH-1:2], 2'b00};
                rnw_q   <= i_lsu_lns;
                ben_q   <= lane_ben(i_lsu_op, i_alu_result[1:0]);
                wdata_q <= lane_wdata(i_lsu_op, i_mem_data);
                err_q   <= 1'b0;
            end
            if ((state_q == S_WAIT) && i_bus_rdy) begin
                err_q  <= i_bus_err;
                berr_q <= i_bus_err;
            end else if (timeout) begin
                err_q  <= 1'b1;
                berr_q <= 1'b1;
            end
            if ((state_q == S_DONE) && !ext_stall) begin
                rd_no_q  <= (rnw_q && !err_q) ? rd_q : '0;
                rd_val_q <= rdata_q;
            end else if ((state_q == S_IDLE) && !core_stall) begin
                rd_no_q  <= (i_nullify || (i_lsu_op != OP_IDLE && misaligned)) ? '0 : i_rd_no;
                rd_val_q <= i_alu_result;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            rd_q   <= i_rd_no;
            size_q <= i_lsu_op;
            lo_q   <= i_alu_result[1:0];
            ext_q  <= i_lsu_ext;
        end
        if ((state_q == S_WAIT) && i_bus_rdy) begin
            rdata_q <= load_align(size_q, lo_q, ext_q, i_bus_data);
        end
    end

    assign o_bus_addr  = addr_q;
    assign o_bus_rnw   = rnw_q;
    assign o_bus_ben   = ben_q;
    assign o_bus_wdata = wdata_q;
    assign o_bus_error = berr_q;
    assign o_rd_no     = rd_no_q;
    assign o_rd_val    = rd_val_q;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: expected writebacks are queued when an instruction is driven
// and compared when the stage retires it.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_exec_stall, i_fetch_stall, i_nullify;
    logic [4:0]  i_rd_no;
    logic [31:0] i_alu_result;
    logic [1:0]  i_lsu_op;
    logic        i_lsu_lns, i_lsu_ext;
    logic [31:0] i_mem_data;
    logic [31:0] o_bus_addr;
    logic        o_bus_cmd, o_bus_rnw;
    logic [31:0] o_bus_wdata;
    logic [3:0]  o_bus_ben;
    logic        i_bus_rdy;
    logic [31:0] i_bus_data;
    logic        i_bus_err;
    logic        o_mem_stall, o_addr_error, o_bus_error;
    logic [4:0]  o_rd_no;
    logic [31:0] o_rd_val;

    mem_access #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .REGNO_WIDTH(5),
        .BUS_TIMEOUT(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_exec_stall (i_exec_stall),
        .i_fetch_stall(i_fetch_stall),
        .i_nullify    (i_nullify),
        .i_rd_no      (i_rd_no),
        .i_alu_result (i_alu_result),
        .i_lsu_op     (i_lsu_op),
        .i_lsu_lns    (i_lsu_lns),
        .i_lsu_ext    (i_lsu_ext),
        .i_mem_data   (i_mem_data),
        .o_bus_addr   (o_bus_addr),
        .o_bus_cmd    (o_bus_cmd),
        .o_bus_rnw    (o_bus_rnw),
        .o_bus_wdata  (o_bus_wdata),
        .o_bus_ben    (o_bus_ben),
        .i_bus_rdy    (i_bus_rdy),
        .i_bus_data   (i_bus_data),
        .i_bus_err    (i_bus_err),
        .o_mem_stall  (o_mem_stall),
        .o_addr_error (o_addr_error),
        .o_bus_error  (o_bus_error),
        .o_rd_no      (o_rd_no),
        .o_rd_val     (o_rd_val)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] val;
        bit          cv;
    } sb_t;

    sb_t        sb[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [4:0] last_rd = 5'd0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_load(input logic [1:0] op, input logic [1:0] a,
                                             input logic ext, input logic [31:0] d);
        logic [31:0] s;
        s = d >> (8 * a);
        case (op)
            2'd1:    return (ext && s[7])  ? ((s & 32'h0000_00FF) | 32'hFFFF_FF00) : (s & 32'h0000_00FF);
            2'd2:    return (ext && s[15]) ? ((s & 32'h0000_FFFF) | 32'hFFFF_0000) : (s & 32'h0000_FFFF);
            default: return d;
        endcase
    endfunction

    function automatic logic [3:0] exp_ben(input logic [1:0] op, input logic [1:0] a);
        case (op)
            2'd1:    return 4'b0001 << a;
            2'd2:    return 4'b0011 << a;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [1:0] op, input logic [31:0] d);
        case (op)
            2'd1:    return {24'd0, d[7:0]} * 32'h0101_0101;
            2'd2:    return {16'd0, d[15:0]} * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    task automatic retire();
        sb_t e;
        if (sb.size() == 0) begin
            chk_eq("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk_eq("rd_no", 32'(o_rd_no), 32'(e.rd));
            if (e.cv) chk_eq("rd_val", o_rd_val, e.val);
            last_rd = e.rd;
        end
    endtask

    task automatic run_pass(input logic [1:0] op, input logic nul, input logic [4:0] rd,
                            input logic [31:0] alu);
        sb_t e;
        i_lsu_op = op; i_lsu_lns = 1'b1; i_nullify = nul; i_rd_no = rd; i_alu_result = alu;
        #1;
        chk_eq("pass_stall", 32'(o_mem_stall), 32'd0);
        chk_eq("pass_cmd", 32'(o_bus_cmd), 32'd0);
        e.rd = nul ? 5'd0 : rd; e.val = alu; e.cv = 1'b1;
        sb.push_back(e);
        step();
        retire();
        i_nullify = 1'b0;
    endtask

    task automatic run_misaligned(input logic [1:0] op, input logic [31:0] addr);
        sb_t e;
        i_lsu_op = op; i_lsu_lns = 1'b1; i_rd_no = 5'd12; i_alu_result = addr;
        #1;
        chk_eq("mis_addr_err", 32'(o_addr_error), 32'd1);
        chk_eq("mis_stall", 32'(o_mem_stall), 32'd0);
        e.rd = 5'd0; e.val = 32'd0; e.cv = 1'b0;
        sb.push_back(e);
        step();
        chk_eq("mis_cmd", 32'(o_bus_cmd), 32'd0);
        retire();
        i_lsu_op = 2'd0;
        #1;
        chk_eq("mis_err_clr", 32'(o_addr_error), 32'd0);
    endtask

    task automatic run_mem(input logic [1:0] op, input logic lns, input logic ext,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                           input int nwait, input logic [31:0] bdata, input logic berr,
                           input int hold);
        sb_t e;
        int  stalls;
        i_lsu_op = op; i_lsu_lns = lns; i_lsu_ext = ext; i_alu_result = addr;
        i_mem_data = wd; i_rd_no = rd; i_nullify = 1'b0;
        #1;
        stalls = int'(o_mem_stall);
        chk_eq("start_cmd", 32'(o_bus_cmd), 32'd0);
        e.rd = (lns && !berr) ? rd : 5'd0;
        e.val = exp_load(op, addr[1:0], ext, bdata);
        e.cv = lns && !berr;
        sb.push_back(e);
        step();
        for (int i = 1; i <= nwait; i++) begin
            chk_eq("wait_cmd", 32'(o_bus_cmd), 32'd1);
            if (i == 1) begin
                chk_eq("bus_addr", o_bus_addr, {addr[31:2], 2'b00});
                chk_eq("bus_ben", 32'(o_bus_ben), 32'(exp_ben(op, addr[1:0])));
                chk_eq("bus_rnw", 32'(o_bus_rnw), 32'(lns));
                if (!lns) chk_eq("bus_wdata", o_bus_wdata, exp_wdata(op, wd));
            end
            stalls += int'(o_mem_stall);
            if (i == nwait) begin
                i_bus_rdy = 1'b1; i_bus_data = bdata; i_bus_err = berr;
            end
            step();
            i_bus_rdy = 1'b0; i_bus_err = 1'b0; i_bus_data = $urandom;
        end
        chk_eq("stall_cycles", 32'(stalls), 32'(nwait + 1));
        chk_eq("done_stall", 32'(o_mem_stall), 32'd0);
        chk_eq("done_cmd", 32'(o_bus_cmd), 32'd0);
        chk_eq("bus_err_pulse", 32'(o_bus_error), 32'(berr));
        if (hold > 0) begin
            i_fetch_stall = 1'b1;
            for (int h = 0; h < hold; h++) begin
                step();
                chk_eq("hold_rd_no", 32'(o_rd_no), 32'(last_rd));
            end
            i_fetch_stall = 1'b0;
        end
        step();
        chk_eq("bus_err_clr", 32'(o_bus_error), 32'd0);
        retire();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        i_exec_stall = 1'b0; i_fetch_stall = 1'b0; i_nullify = 1'b0;
        i_rd_no = '0; i_alu_result = '0; i_lsu_op = '0; i_lsu_lns = 1'b0; i_lsu_ext = 1'b0;
        i_mem_data = '0; i_bus_rdy = 1'b0; i_bus_data = '0; i_bus_err = 1'b0;
        step();
        step();
        chk_eq("rst_rd_no", 32'(o_rd_no), 32'd0);
        chk_eq("rst_rd_val", o_rd_val, 32'd0);
        chk_eq("rst_cmd", 32'(o_bus_cmd), 32'd0);
        chk_eq("rst_bus_err", 32'(o_bus_error), 32'd0);
        chk_eq("rst_ben", 32'(o_bus_ben), 32'd0);
        rst = 1'b0;

        run_pass(2'd0, 1'b0, 5'd5, 32'h0000_1234);
        run_mem(2'd1, 1'b1, 1'b1, 32'h0000_1003, 32'h0, 5'd9, 2, 32'h80FF_FFFF, 1'b0, 0);
        run_mem(2'd1, 1'b1, 1'b0, 32'h0000_1001, 32'h0, 5'd10, 1, 32'h1234_8056, 1'b0, 0);
        run_mem(2'd2, 1'b1, 1'b1, 32'h0000_1002, 32'h0, 5'd11, 1, 32'h8001_7777, 1'b0, 0);
        run_mem(2'd2, 1'b1, 1'b0, 32'h0000_1000, 32'h0, 5'd13, 2, 32'h1111_F00D, 1'b0, 0);
        run_mem(2'd3, 1'b1, 1'b0, 32'h0000_1004, 32'h0, 5'd14, 3, 32'hCAFE_BABE, 1'b0, 0);
        run_mem(2'd2, 1'b0, 1'b0, 32'h0000_2002, 32'hDEAD_BEEF, 5'd15, 1, 32'h0, 1'b0, 0);
        run_mem(2'd1, 1'b0, 1'b0, 32'h0000_2001, 32'h0000_00AB, 5'd16, 1, 32'h0, 1'b0, 0);
        run_mem(2'd3, 1'b0, 1'b0, 32'h0000_2000, 32'h0123_4567, 5'd17, 2, 32'h0, 1'b0, 0);
        run_misaligned(2'd3, 32'h0000_2001);
        run_misaligned(2'd2, 32'h0000_2003);
        run_mem(2'd3, 1'b1, 1'b0, 32'h0000_3000, 32'h0, 5'd18, 1, 32'h5555_AAAA, 1'b1, 0);
        run_mem(2'd3, 1'b1, 1'b0, 32'h0000_3008, 32'h0, 5'd19, 1, 32'h0BAD_F00D, 1'b0, 3);
        run_pass(2'd3, 1'b1, 5'd20, 32'h0000_4000);

        for (int k = 0; k < 20; k++) begin
            logic [1:0]  op;
            logic [31:0] a;
            op = 2'($urandom_range(1, 3));
            a  = $urandom & 32'hFFFF_FFFC;
            if (op == 2'd1) a[1:0] = 2'($urandom_range(0, 3));
            if (op == 2'd2) a[1]   = 1'($urandom_range(0, 1));
            run_mem(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
                    5'($urandom_range(1, 31)), $urandom_range(1, 3), $urandom,
                    1'($urandom_range(0, 7) == 0), $urandom_range(0, 1));
        end

`ifdef MEM_BUS_TIMEOUT_EN
        begin
            sb_t e;
            i_lsu_op = 2'd3; i_lsu_lns = 1'b1; i_alu_result = 32'h0000_5000; i_rd_no = 5'd7;
            #1;
            e.rd = 5'd0; e.val = 32'd0; e.cv = 1'b0;
            sb.push_back(e);
            step();
            for (int i = 0; i < 4; i++) begin
                chk_eq("to_wait_cmd", 32'(o_bus_cmd), 32'd1);
                step();
            end
            chk_eq("to_cmd_drop", 32'(o_bus_cmd), 32'd0);
            chk_eq("to_bus_err", 32'(o_bus_error), 32'd1);
            step();
            retire();
        end
`endif

        i_lsu_op = 2'd3; i_lsu_lns = 1'b1; i_alu_result = 32'h0000_6004; i_rd_no = 5'd21;
        #1;
        step();
        chk_eq("rw_cmd", 32'(o_bus_cmd), 32'd1);
        rst = 1'b1;
        step();
        chk_eq("rw_cmd_drop", 32'(o_bus_cmd), 32'd0);
        chk_eq("rw_rd_no", 32'(o_rd_no), 32'd0);
        rst = 1'b0;
        last_rd = 5'd0;
        run_pass(2'd0, 1'b0, 5'd3, 32'h0000_CAFE);

        chk_eq("sb_drain", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory access pipeline stage that sits directly downstream of the execute stage.
- Consumes execute's rd_no, alu_result (effective address or ALU value), lsu_op/lns/ext and mem_data.
- Runs load/store transactions on the data bus via a req/rdy handshake and aligns/extends load data.
- Presents a registered destination register number and value to writeback, and raises the memory stall and error signals to the CU.

Parameters:
- ADDR_WIDTH, 32, byte-address width (equals CPU_ADDR_WIDTH).
- DATA_WIDTH, 32, data/register width (equals CPU_REG_WIDTH).
- REGNO_WIDTH, 5, register number width.
- BUS_TIMEOUT, 255, max WAIT cycles before abort (used only with MEM_BUS_TIMEOUT_EN).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset: synchronous, active-high.
- i_exec_stall  in  1  execute stall from CU.
- i_fetch_stall  in  1  fetch stall from CU.
- i_nullify  in  1  squash the incoming instruction.
- i_rd_no  in  REGNO_WIDTH  destination register from execute.
- i_alu_result  in  DATA_WIDTH  ALU result / effective address.
- i_lsu_op  in  2  0=IDLE, 1=BYTE, 2=HALF, 3=WORD.
- i_lsu_lns  in  1  1=load, 0=store.
- i_lsu_ext  in  1  1=sign-extend load, 0=zero-extend.
- i_mem_data  in  DATA_WIDTH  store data (rt).
- o_bus_addr  out  ADDR_WIDTH  word-aligned address ({addr[31:2],2'b00}).
- o_bus_cmd  out  1  request valid.
- o_bus_rnw  out  1  1=read, 0=write.
- o_bus_wdata  out  DATA_WIDTH  lane-replicated store data.
- o_bus_ben  out  4  byte enables.
- i_bus_rdy  in  1  request accepted/completed this cycle.
- i_bus_data  in  DATA_WIDTH  read data, valid with i_bus_rdy.
- i_bus_err  in  1  bus error, valid with i_bus_rdy.
- o_mem_stall  out  1  stage busy; CU freezes pipeline.
- o_addr_error  out  1  misaligned access pulse.
- o_bus_error  out  1  bus error pulse.
- o_rd_no  out  REGNO_WIDTH  writeback register number (0 = no write).
- o_rd_val  out  DATA_WIDTH  writeback value.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, all outputs 0.
- Reset mid-transaction drops o_bus_cmd on the next edge; no completion is reported.
- core_stall = i_exec_stall | i_fetch_stall | o_mem_stall.
- o_rd_no and o_rd_val update only when !core_stall.

Non-memory instruction (i_lsu_op=IDLE or i_nullify):
- Pass-through with 1-cycle latency: o_rd_no <= nullify ? 0 : i_rd_no; o_rd_val <= i_alu_result.
- No stall.

Alignment:
- HALF with addr[0]=1 → misaligned.
- WORD with addr[1:0]≠0 → misaligned.
- On misaligned in IDLE: o_addr_error=1 for one cycle (combinational), no bus cycle, o_rd_no <= 0, no stall.

FSM (little-endian lanes):
- IDLE: valid aligned op with !i_nullify → o_mem_stall=1; latch address, rnw=lns, ben, wdata, rd_no, size, ext; go WAIT.
- WAIT: o_bus_cmd=1 and all bus outputs held stable. o_mem_stall=1.
  - i_bus_rdy=0 → stay in WAIT.
  - i_bus_rdy=1 → capture aligned/extended read data (or bus error); go DONE.
- DONE: o_mem_stall=0.
  - If !(i_exec_stall|i_fetch_stall): o_rd_no <= (load & !err) ? latched rd : 0; o_rd_val <= load data; go IDLE.
  - Otherwise stay in DONE.
- o_bus_error pulses for one cycle on entry to DONE when i_bus_err=1.
- Minimum memory-op occupancy is 3 cycles: IDLE detect, WAIT with rdy, DONE.

Store lanes:
- BYTE: wdata = {4{d[7:0]}}, ben = 1<<addr[1:0].
- HALF: wdata = {2{d[15:0]}}, ben = addr[1] ? 4'b1100 : 4'b0011.
- WORD: wdata = d, ben = 4'b1111.

Load lanes:
- Select the byte or half by addr, then sign- or zero-extend per ext.
- For a read, ben follows the same per-size rules as a store.

Other rules:
- i_nullify is sampled only in IDLE; it has no effect in WAIT or DONE.
- While in WAIT or DONE, the execute-stage inputs are held stable by the stall.

Optional Feature:
- MEM_BUS_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to WAIT and increments each WAIT cycle without i_bus_rdy.
  - When the count reaches BUS_TIMEOUT: drop cmd, go DONE with the error flag set, pulse o_bus_error, o_rd_no=0.
- MEM_BUS_TIMEOUT_EN undefined: no counter; WAIT lasts until i_bus_rdy, unbounded.

Test Plan:
- Non-memory passthrough: i_lsu_op=0, rd=5, alu=0x1234 → next cycle o_rd_no=5, o_rd_val=0x1234; o_mem_stall never 1.
- Signed byte load:
  - Stimulus: LB addr 0x1003, ext=1, rdy after 2 WAIT cycles with bus_data=0x80FFFFFF.
  - Bus side: o_bus_addr=0x1000, ben=4'b1000.
  - Stall: o_mem_stall high for 3 cycles.
  - Result: o_rd_val=0xFFFFFF80.
- Half store: SH addr 0x2002, data 0xDEADBEEF → wdata=0xBEEFBEEF, ben=4'b1100, rnw=0, o_rd_no=0.
- Misaligned: LW addr 0x2001 → o_addr_error 1 cycle; o_bus_cmd stays 0; o_rd_no=0.
- Bus error and downstream hold:
  - LW with rdy=1, err=1 → o_bus_error pulse, o_rd_no=0.
  - LW completing with i_fetch_stall=1 → FSM holds DONE, outputs update only after the stall drops.
- Timeout and reset:
  - With MEM_BUS_TIMEOUT_EN and BUS_TIMEOUT=4, rdy never asserted → abort after 4 WAIT cycles, o_bus_error=1.
  - rst asserted in WAIT → o_bus_cmd=0 and state IDLE next cycle.
